spi_reg_peripheral: RTL
=======================

Name: spi_reg_peripheral

Overview:
SPI-slave register bank that sits directly upstream of the PWM peripheral inside the top-level user project. It receives 16-bit write transactions from an external SPI controller on the dedicated input pins. It decodes them into five 8-bit control registers that drive output enables, PWM enables and PWM duty cycle. SCLK, COPI and nCS are asynchronous to clk and are oversampled; no logic is clocked by SCLK.

Parameters:
SYNC_STAGES, 2, synchroniser flops per SPI input (minimum 2)
MAX_ADDR, 7'h04, highest valid register address; writes above it are discarded

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock, mode 0 (sample on rising edge), asynchronous
copi  input  1  SPI controller-out data, MSB first, asynchronous
ncs  input  1  SPI chip select, active low, asynchronous
en_reg_out_7_0  output  8  register 0x00: output enables uo_out[7:0]
en_reg_out_15_8  output  8  register 0x01: output enables uio_out[7:0]
en_reg_pwm_7_0  output  8  register 0x02: PWM-mode select for uo_out[7:0]
en_reg_pwm_15_8  output  8  register 0x03: PWM-mode select for uio_out[7:0]
pwm_duty_cycle  output  8  register 0x04: duty cycle, 0x00 = 0 %, 0xFF = 100 %
wr_strobe  output  1  one-clk pulse when a register is committed
txn_err  output  1  one-clk pulse when a completed transaction is discarded

Behaviour:
- Reset: all five registers = 8'h00; wr_strobe = 0; txn_err = 0; shift register, bit counter and synchronisers cleared (sync flops reset so that ncs is high/idle and sclk is low).
- Sync: sclk, copi and ncs each pass through SYNC_STAGES flops. Edges are detected by comparing the last sync stage with one further delayed flop.
- Frame format: 16 bits, MSB first. Bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- States:
  - IDLE. Synced ncs falling edge → clear bit counter and overflow flag → RECV.
  - RECV. On each synced sclk rising edge, shift synced copi into the 16-bit shift register LSB and increment the counter. The counter saturates at 17 and sets the overflow flag. On synced ncs rising edge → COMMIT.
  - COMMIT. Lasts exactly one cycle, then → IDLE.
- COMMIT rules:
  - Write occurs only if count == 16, no overflow, R/W == 1 and addr <= MAX_ADDR. The addressed register takes the data and wr_strobe = 1 for that cycle.
  - Otherwise no register changes and txn_err = 1 for that cycle.
  - Read frames (R/W == 0) count as discarded; this block has no read-back path.
- Latency: the register output changes on the 2nd clk rising edge after the edge that detects synced ncs high. Pad ncs rising to register update takes SYNC_STAGES+2 clk edges, i.e. 4 with the default.
- sclk edges while synced ncs is high are ignored.
- ncs glitch low with 0 sclk edges: count 0, so the frame is discarded with txn_err.
- Back-to-back frames: ncs may fall again in the cycle after COMMIT. Data of a frame never mixes with the next.
- Timing requirement on the bench: sclk high and low phases each ≥ SYNC_STAGES+2 clk periods; ncs high ≥ 4 clk between frames.
- rst_n asserted mid-frame: immediate return to IDLE, registers cleared. A partial frame is never committed, including when ncs rises after reset is released.
- Registers hold their value indefinitely between writes. Rewriting the same value still pulses wr_strobe.

Test Plan:
- Reset: assert rst_n = 0 for 5 clk then release → all five registers read 0x00, wr_strobe and txn_err stay 0 for 20 clk.
- Write sequence 0x80F0, 0x81CC, 0x82FF, 0x8355, 0x8480 with sclk = clk/10 → registers read F0, CC, FF, 55, 80 in order. One wr_strobe per frame; each update lands 4 clk after pad ncs rises.
- Invalid address 0x8F_AA and read frame 0x00_12 → all registers unchanged, one txn_err pulse per frame, no wr_strobe.
- Malformed length: 15-bit frame then 17-bit frame, both targeting 0x04 → pwm_duty_cycle unchanged, two txn_err pulses.
- Reset mid-frame: drive 8 bits of 0x8433, pulse rst_n low, finish the remaining bits and raise ncs → pwm_duty_cycle = 0x00. A following clean 0x8433 yields 0x33.
- sclk toggling while ncs high: toggle sclk 32 times with copi random, then send 0x8007 → only en_reg_out_7_0 = 0x07, with exactly one wr_strobe.

Source files
------------

// File: rtl/spi_reg_peripheral.sv
// SPI-slave (mode 0) register bank: oversamples sclk/copi/ncs in the clk domain
// and commits 16-bit write frames into five 8-bit control registers.
module spi_reg_peripheral #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe,
   output logic       txn_err
);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      COMMIT
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
   logic                   sclk_dly, ncs_dly;
   logic                   sclk_s, copi_s, ncs_s;
   logic                   sclk_rise, ncs_fall, ncs_rise;

   logic [15:0] shift_q;
   logic [4:0]  cnt_q;
   logic        ovf_q;
   logic        clr_frame, shift_en, commit;
   logic        frame_ok;
   logic [6:0]  addr;
   logic [7:0]  data;

   // Synchronisers reset to the bus idle levels (ncs high, sclk low) so that
   // leaving reset never looks like the end of a frame.
   // NOTE: clocked state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         copi_sync <= '0;
         ncs_sync  <= '1;
         sclk_dly  <= 1'b0;
         ncs_dly   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
         ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
         sclk_dly  <= sclk_sync[SYNC_STAGES-1];
         ncs_dly   <= ncs_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign copi_s    = copi_sync[SYNC_STAGES-1];
   assign ncs_s     = ncs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_dly;
   assign ncs_fall  = ~ncs_s & ncs_dly;
   assign ncs_rise  = ncs_s & ~ncs_dly;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, otherwise any
   // path through the case that skips an assignment infers a latch.
   always_comb begin
      state_nxt = state;
      clr_frame = 1'b0;
      shift_en  = 1'b0;
      commit    = 1'b0;
      unique case (state)
         IDLE: begin
            if (ncs_fall) begin
               clr_frame = 1'b1;
               state_nxt = RECV;
            end
         end
         RECV: begin
            shift_en = sclk_rise;
            if (ncs_rise) state_nxt = COMMIT;
         end
         COMMIT: begin
            commit    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bit counter saturates at 17; any count above 16 marks the frame as overlong.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= 16'h0000;
         cnt_q   <= 5'd0;
         ovf_q   <= 1'b0;
      end else if (clr_frame) begin
         shift_q <= 16'h0000;
         cnt_q   <= 5'd0;
         ovf_q   <= 1'b0;
      end else if (shift_en) begin
         shift_q <= {shift_q[14:0], copi_s};
         if (cnt_q >= 5'd16) begin
            cnt_q <= 5'd17;
            ovf_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + 5'd1;
         end
      end
   end

   assign addr     = shift_q[14:8];
   assign data     = shift_q[7:0];
   assign frame_ok = (cnt_q == 5'd16) && !ovf_q && shift_q[15] && (addr <= MAX_ADDR);

   // NOTE: the register bank is built from individual flops, so it is reset
   // like any other state; a RAM-style array would not be.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_reg_out_7_0  <= 8'h00;
         en_reg_out_15_8 <= 8'h00;
         en_reg_pwm_7_0  <= 8'h00;
         en_reg_pwm_15_8 <= 8'h00;
         pwm_duty_cycle  <= 8'h00;
         wr_strobe       <= 1'b0;
         txn_err         <= 1'b0;
      end else begin
         wr_strobe <= 1'b0;
         txn_err   <= 1'b0;
         if (commit) begin
            if (frame_ok) begin
               wr_strobe <= 1'b1;
               case (addr)
                  7'd0:    en_reg_out_7_0  <= data;
                  7'd1:    en_reg_out_15_8 <= data;
                  7'd2:    en_reg_pwm_7_0  <= data;
                  7'd3:    en_reg_pwm_15_8 <= data;
                  7'd4:    pwm_duty_cycle  <= data;
                  default: ;
               endcase
            end else begin
               txn_err <= 1'b1;
            end
         end
      end
   end

endmodule
